// File: rtl/input_channel_fifo.sv
// DEPTH-entry router input channel FIFO with hop-field decode and switch-allocator request.
// Optional feature macro: HOP_DEC_EN (head packet is presented with its hop field decremented).
module input_channel_fifo #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int HOP_MSB = 55,
  parameter int HOP_LSB = 48
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          di,
  input  logic                       WE,
  output logic                       full,
  input  logic                       grant,
  output logic [DATA_W-1:0]          packet,
  output logic                       request,
  output logic                       ToPE,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = HOP_MSB - HOP_LSB + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
`ifdef HOP_DEC_EN
  localparam logic [HW-1:0] HOP_ONE  = {{(HW-1){1'b0}}, 1'b1};
`endif

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              ovf_r;

  logic              full_s;
  logic              valid_s;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] head_s;
  logic [HW-1:0]     hop_s;

  // full depends only on registered count, so a same-cycle grant cannot open a slot
  assign full_s  = (count_r == FULL_CNT);
  assign valid_s = (count_r != {CW{1'b0}});
  assign push_s  = WE && !full_s;
  assign pop_s   = grant && valid_s;
  assign head_s  = mem_r[rd_ptr_r];
  assign hop_s   = head_s[HOP_MSB:HOP_LSB];

  // Pointer, occupancy and sticky overflow state
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (WE && full_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Packet storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      mem_r[wr_ptr_r] <= di;
    end
  end

  // Head presentation and local-PE decode from registered state
  always_comb begin
    packet = {DATA_W{1'b0}};
    ToPE   = 1'b0;
    if (valid_s) begin
      packet = head_s;
      ToPE   = (hop_s == {HW{1'b0}});
`ifdef HOP_DEC_EN
      if (hop_s != {HW{1'b0}}) begin
        packet[HOP_MSB:HOP_LSB] = hop_s - HOP_ONE;
      end else begin
        packet[HOP_MSB:HOP_LSB] = hop_s;
      end
`endif
    end else begin
      packet = {DATA_W{1'b0}};
      ToPE   = 1'b0;
    end
  end

  assign full    = full_s;
  assign request = valid_s;
  assign count   = count_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_input_channel_fifo.sv
// Scoreboard bench for input_channel_fifo: directed corner cases followed by random traffic.
module tb_input_channel_fifo;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CW     = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] di = '0;
  logic              WE = 1'b0;
  logic              grant = 1'b0;
  logic              full;
  logic [DATA_W-1:0] packet;
  logic              request;
  logic              ToPE;
  logic [CW-1:0]     count;
  logic              ovf;

  input_channel_fifo #(.DATA_W(64), .DEPTH(4), .HOP_MSB(55), .HOP_LSB(48)) dut (
    .clk(clk), .reset(reset), .di(di), .WE(WE), .full(full), .grant(grant),
    .packet(packet), .request(request), .ToPE(ToPE), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          occ = 0;
  bit          exp_ovf = 1'b0;
  bit          mon_en = 1'b0;

  // Reference view of a stored packet as the head output should show it
  function automatic logic [63:0] view(input logic [63:0] p);
    logic [7:0] h;
    h = p[55:48];
`ifdef HOP_DEC_EN
    if (h != 8'd0) p[55:48] = h - 8'd1;
`endif
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Apply the previous cycle's effect to the model, then issue new stimulus
  task automatic drive(input bit rst, input bit we, input bit gr, input logic [63:0] d);
    int pu;
    int po;
    @(posedge clk);
    #1;
    if (!reset) begin
      occ = 0;
      exp_ovf = 1'b0;
      exp_q.delete();
    end else begin
      pu = (WE && occ < DEPTH) ? 1 : 0;
      po = (grant && occ > 0) ? 1 : 0;
      if (WE && occ == DEPTH) exp_ovf = 1'b1;
      occ = occ + pu - po;
    end
    reset = rst;
    WE    = we;
    grant = gr;
    di    = d;
    if (rst && we && occ < DEPTH) exp_q.push_back(d);
  endtask

  // Monitor: compare presented state mid-cycle and retire popped packets
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 64'(count), 64'(occ));
      check("full", 64'(full), 64'(occ == DEPTH));
      check("request", 64'(request), 64'(occ != 0));
      check("ovf", 64'(ovf), 64'(exp_ovf));
      if (occ > 0 && exp_q.size() > 0) begin
        check("packet", packet, view(exp_q[0]));
        check("ToPE", 64'(ToPE), 64'(exp_q[0][55:48] == 8'd0));
      end else if (occ > 0) begin
        check("model_head", 64'(exp_q.size()), 64'(occ));
      end else begin
        check("packet_empty", packet, 64'd0);
        check("ToPE_empty", 64'(ToPE), 64'd0);
      end
      if (request && grant && reset) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 64'd1, 64'd0);
        end else begin
          check("pop_data", packet, view(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [63:0] d;
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    mon_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    // hop=1 packet into empty FIFO, then drain
    drive(1'b1, 1'b1, 1'b0, 64'h0001_0000_0000_00AA);
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 1'b0, 1'b1, 64'd0);
    // fill with hop=0 packets plus a fifth write that overflows
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_0010 + 64'(i));
    // full with simultaneous write and grant: pop only
    drive(1'b1, 1'b1, 1'b1, 64'h0000_DEAD_0000_BEEF);
    drive(1'b1, 1'b0, 1'b1, 64'd0);
    // count=2 with simultaneous write and grant
    drive(1'b1, 1'b1, 1'b1, 64'h0002_0000_0000_0022);
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 64'd0);
    // wrap: fill, drain 3, then six more pushes interleaved with grants
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, {8'h00, 8'(i % 2), 48'h0000_0000_0100 + 48'(i)});
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 64'd0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, (i % 2) == 1, {8'h00, 8'(i + 2), 48'h0000_0000_0200 + 48'(i)});
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, 64'd0);
    // reset mid-stream with a write and grant in flight
    drive(1'b1, 1'b1, 1'b0, 64'h0003_0000_0000_0033);
    drive(1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_0044);
    drive(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0055);
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: d[55:48] = 8'd0;
        1: d[55:48] = 8'd1;
        2: d = 64'd0;
        default: d = d;
      endcase
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1), d);
    end
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
